// File: rtl/sat_accumulate_stream_pkg.sv
// Shared types, limits and the saturating add helper
// for the packet accumulator.
package sat_pkg;

   localparam int SAT_ACC_W = 6;
   localparam int ACC_MAX   = (1 << (SAT_ACC_W - 1)) - 1;
   localparam int ACC_MIN   = -(1 << (SAT_ACC_W - 1));

   typedef enum logic {ACC, HOLD} sat_acc_state_t;

   typedef struct packed {
      logic signed [31:0] sum;
      logic               ovf;
   } sat_res_t;

   // Add two sign-extended operands, clamp to a signed w-bit range.
   function automatic sat_res_t sat_add(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input int                 w
   );
      logic signed [32:0] s;
      logic signed [32:0] mx;
      logic signed [32:0] mn;
      sat_res_t           r;
      s     = 33'(a) + 33'(b);
      mx    = (33'sd1 <<< (w - 1)) - 33'sd1;
      mn    = -(33'sd1 <<< (w - 1));
      r.sum = s[31:0];
      r.ovf = 1'b0;
      if (s > mx) begin
         r.sum = mx[31:0];
         r.ovf = 1'b1;
      end else if (s < mn) begin
         r.sum = mn[31:0];
         r.ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sat_accumulate_stream_if.sv
// Sample-in / result-out handshake bundle.
// slave: the accumulator; master: the producer/consumer side.
interface sat_accumulate_stream_if #(
   parameter int W     = 4,
   parameter int ACC_W = 6,
   parameter int CNT_W = 8
);
   logic             up_valid;
   logic             up_ready;
   logic [W-1:0]     up_data;
   logic             up_last;
   logic             down_valid;
   logic             down_ready;
   logic [ACC_W-1:0] down_data;
   logic             down_sat;
   logic [CNT_W-1:0] down_count;

   modport slave (
      input  up_valid, up_data, up_last, down_ready,
      output up_ready, down_valid, down_data, down_sat, down_count
   );

   modport master (
      output up_valid, up_data, up_last, down_ready,
      input  up_ready, down_valid, down_data, down_sat, down_count
   );
endinterface

// File: rtl/sat_accumulate_stream_add.sv
// Combinational saturating signed adder, WR-bit result.
// Ports: a_i (WA), b_i (WB), y_o (WR), ovf_o clamp flag.
module sat_add_w
   import sat_pkg::*;
#(
   parameter int WA = 6,
   parameter int WB = 4,
   parameter int WR = 6
) (
   input  logic signed [WA-1:0] a_i,
   input  logic signed [WB-1:0] b_i,
   output logic signed [WR-1:0] y_o,
   output logic                 ovf_o
);
   sat_res_t r;

   always_comb begin
      r = sat_add(32'(a_i), 32'(b_i), WR);
   end

   assign y_o   = r.sum[WR-1:0];
   assign ovf_o = r.ovf;

   generate
      if (WR < 32) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^r.sum[31:WR];
      end
   endgenerate
endmodule

// File: rtl/sat_accumulate_stream.sv
// Per-packet saturating accumulator with a registered result.
// Ports: clk, rst_n, bus (slave: up_* samples in, down_* results out).
module sat_accumulate_stream
   import sat_pkg::*;
#(
   parameter int W     = 4,
   parameter int ACC_W = 6,
   parameter int CNT_W = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   sat_accumulate_stream_if.slave   bus
);
   sat_acc_state_t          state_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    sat_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [ACC_W-1:0]        dd_q;
   logic                    ds_q;
   logic [CNT_W-1:0]        dc_q;

   logic signed [ACC_W-1:0] base;
   logic                    base_sat;
   logic [CNT_W-1:0]        base_cnt;
   logic signed [ACC_W-1:0] sum_d;
   logic                    ovf;
   logic                    sat_d;
   logic [CNT_W-1:0]        cnt_d;
   logic                    hold;
   logic                    up_acc;
   logic                    dn_acc;

   assign hold          = (state_q == HOLD);
   assign bus.up_ready  = !hold | bus.down_ready;
   assign up_acc        = bus.up_valid & bus.up_ready;
   assign dn_acc        = hold & bus.down_ready;

   // A sample taken while a result is held opens a new packet.
   assign base     = hold ? '0 : acc_q;
   assign base_sat = hold ? 1'b0 : sat_q;
   assign base_cnt = hold ? '0 : cnt_q;

   sat_add_w #(
      .WA(ACC_W),
      .WB(W),
      .WR(ACC_W)
   ) u_add (
      .a_i  (base),
      .b_i  ($signed(bus.up_data)),
      .y_o  (sum_d),
      .ovf_o(ovf)
   );

   assign sat_d = base_sat | ovf;
   assign cnt_d = (&base_cnt) ? base_cnt : base_cnt + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACC;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         cnt_q   <= '0;
         dd_q    <= '0;
         ds_q    <= 1'b0;
         dc_q    <= '0;
      end else if (up_acc) begin
         if (bus.up_last) begin
            dd_q    <= sum_d;
            ds_q    <= sat_d;
            dc_q    <= cnt_d;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= HOLD;
         end else begin
            acc_q   <= sum_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            state_q <= ACC;
         end
      end else if (dn_acc) begin
         state_q <= ACC;
      end
   end

   assign bus.down_valid = hold;
   assign bus.down_data  = dd_q;
   assign bus.down_sat   = ds_q;
   assign bus.down_count = dc_q;
endmodule

// File: tb/tb_sat_accumulate_stream.sv
// Bench: spec-level packet model checked every cycle,
// plus hand-computed literal results for each directed packet.
module tb_sat_accumulate_stream;
   logic clk = 1'b0;
   logic rst_n;

   sat_accumulate_stream_if #(.W(4), .ACC_W(6), .CNT_W(8)) bus ();

   sat_accumulate_stream #(.W(4), .ACC_W(6), .CNT_W(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: running packet total in plain integers, result slot.
   int m_sum, m_cnt;
   bit m_sat;
   bit e_valid, e_sat;
   int e_data, e_cnt;
   bit m_rdy, m_sacc, m_racc;
   int m_s, m_b, m_bc;
   bit m_bs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sum = 0; m_cnt = 0; m_sat = 0;
         e_valid = 0; e_data = 0; e_sat = 0; e_cnt = 0;
      end else begin
         m_rdy  = !e_valid || bus.down_ready;
         m_sacc = bus.up_valid && m_rdy;
         m_racc = e_valid && bus.down_ready;
         if (m_racc) e_valid = 0;
         if (m_sacc) begin
            m_b  = m_racc ? 0 : m_sum;
            m_bs = m_racc ? 0 : m_sat;
            m_bc = m_racc ? 0 : m_cnt;
            m_s  = m_b + int'($signed(bus.up_data));
            if (m_s > 31) begin m_s = 31; m_bs = 1; end
            if (m_s < -32) begin m_s = -32; m_bs = 1; end
            m_bc = (m_bc >= 255) ? 255 : m_bc + 1;
            if (bus.up_last) begin
               e_valid = 1; e_data = m_s; e_sat = m_bs; e_cnt = m_bc;
               m_sum = 0; m_sat = 0; m_cnt = 0;
            end else begin
               m_sum = m_s; m_sat = m_bs; m_cnt = m_bc;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            chk("mdl_valid", int'(bus.down_valid), int'(e_valid));
            chk("mdl_ready", int'(bus.up_ready),
                int'(!e_valid || bus.down_ready));
            if (e_valid) begin
               chk("mdl_data", int'($signed(bus.down_data)), e_data);
               chk("mdl_sat", int'(bus.down_sat), int'(e_sat));
               chk("mdl_cnt", int'(bus.down_count), e_cnt);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic send(input int d, input bit l);
      int t;
      logic [3:0] dv;
      t  = 0;
      dv = d[3:0];
      bus.up_valid = 1'b1;
      bus.up_data  = dv;
      bus.up_last  = l;
      while (!bus.up_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("send_timeout", t, 0);
      @(posedge clk);
      @(negedge clk);
      bus.up_valid = 1'b0;
      bus.up_data  = 4'hA;
      bus.up_last  = 1'b1;
   endtask

   task automatic expect_res(input string n, input int d,
                             input int s, input int c);
      chk({n, "_valid"}, int'(bus.down_valid), 1);
      chk({n, "_data"}, int'($signed(bus.down_data)), d);
      chk({n, "_sat"}, int'(bus.down_sat), s);
      chk({n, "_cnt"}, int'(bus.down_count), c);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.up_valid   = 1'b0;
      bus.up_data    = '0;
      bus.up_last    = 1'b0;
      bus.down_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_valid", int'(bus.down_valid), 0);
      chk("rst_data", int'(bus.down_data), 0);
      chk("rst_sat", int'(bus.down_sat), 0);
      chk("rst_cnt", int'(bus.down_count), 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(3, 1);
      expect_res("p1", 3, 0, 1);

      repeat (4) send(7, 0);
      send(7, 1);
      expect_res("p2", 31, 1, 5);

      repeat (4) send(-8, 0);
      send(-8, 1);
      expect_res("p3", -32, 1, 5);

      repeat (5) send(7, 0);
      send(-8, 1);
      expect_res("p4", 23, 1, 6);
      @(negedge clk);
      chk("idle_valid", int'(bus.down_valid), 0);

      bus.down_ready = 1'b0;
      send(4, 1);
      for (int i = 0; i < 4; i++) begin
         bus.up_valid = 1'b1;
         bus.up_data  = 4'd5;
         bus.up_last  = 1'b1;
         chk("bp_ready", int'(bus.up_ready), 0);
         expect_res("bp", 4, 0, 1);
         @(negedge clk);
      end
      bus.down_ready = 1'b1;
      send(2, 1);
      expect_res("b2b", 2, 0, 1);
      @(negedge clk);
      chk("b2b_drain", int'(bus.down_valid), 0);

      send(5, 0);
      send(5, 0);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", int'(bus.down_valid), 0);
      chk("mid_rst_data", int'(bus.down_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(1, 1);
      expect_res("p_rst", 1, 0, 1);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
